// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types: FSM encoding, queue entry layout and default widths.
package cpu_fetch_pkg;

    localparam int FETCH_AW = 32;
    localparam int FETCH_DW = 32;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_DW-1:0] instr;
        logic                filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: PC written at request acceptance, instruction written at response,
// head entry read asynchronously. Contents are not reset; validity is tracked by the owner.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          pc_we,
    input  logic [PW-1:0] pc_waddr,
    input  logic [AW-1:0] pc_wdata,
    input  logic          instr_we,
    input  logic [PW-1:0] instr_waddr,
    input  logic [DW-1:0] instr_wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rd_pc,
    output logic [DW-1:0] rd_instr
);

    logic [AW-1:0] pc_q    [DEPTH];
    logic [DW-1:0] instr_q [DEPTH];

    always_ff @(posedge clock) begin
        if (pc_we) pc_q[pc_waddr] <= pc_wdata;
    end

    always_ff @(posedge clock) begin
        if (instr_we) instr_q[instr_waddr] <= instr_wdata;
    end

    assign rd_pc    = pc_q[raddr];
    assign rd_instr = instr_q[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: issues PC requests, reserves a queue slot per request and
// fills it on response; a redirect empties the queue and drops responses still in flight.
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = FETCH_AW,
    parameter int DW    = FETCH_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    output logic          pc_advance,
    input  logic          redirect,
    output logic          imem_req_valid,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_req_ready,
    input  logic          imem_rsp_valid,
    input  logic [DW-1:0] imem_rsp_data,
    output logic          out_valid,
    output logic [AW-1:0] out_pc,
    output logic [DW-1:0] out_instr,
    input  logic          out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_state_t     state, state_nx;
    logic [PW-1:0]    wr_ptr, rd_ptr, fill_ptr;
    logic [CW-1:0]    used, pending, drop_cnt, drop_nx;
    logic [DEPTH-1:0] filled;
    logic             accept, pop, fill, flush_q;
    logic [AW-1:0]    head_pc;
    logic [DW-1:0]    head_instr;

    // Gated by reset so nothing is requested while the block is held in reset.
    assign imem_req_valid = reset & (state == FETCH_RUN) & (used < CW'(DEPTH)) & ~redirect;
    assign imem_req_addr  = pc_in;
    assign accept         = imem_req_valid & imem_req_ready;
    assign pc_advance     = accept;

    assign out_valid = (used != '0) & filled[rd_ptr];
    assign out_pc    = out_valid ? head_pc : '0;
    assign out_instr = out_valid ? head_instr : '0;

    assign flush_q = redirect & (state == FETCH_RUN);
    assign pop     = out_valid & out_ready & ~redirect;
    assign fill    = imem_rsp_valid & (state == FETCH_RUN) & ~redirect;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= FETCH_RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            drop_cnt <= drop_nx;
        end
    end

    always_comb begin
        state_nx = state;
        drop_nx  = drop_cnt;
        unique case (state)
            FETCH_RUN: begin
                if (redirect) begin
                    // A response landing in the redirect cycle belongs to the killed stream.
                    drop_nx  = (imem_rsp_valid && pending != '0) ? pending - CW'(1) : pending;
                    state_nx = (drop_nx != '0) ? FETCH_FLUSH : FETCH_RUN;
                end
            end
            FETCH_FLUSH: begin
                if (imem_rsp_valid && drop_cnt != '0) drop_nx = drop_cnt - CW'(1);
                if (drop_nx == '0) state_nx = FETCH_RUN;
            end
            default: state_nx = FETCH_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_ptr <= '0;
            used     <= '0;
            pending  <= '0;
            filled   <= '0;
        end else if (flush_q) begin
            rd_ptr   <= wr_ptr;
            fill_ptr <= wr_ptr;
            used     <= '0;
            pending  <= '0;
            filled   <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (fill) fill_ptr <= fill_ptr + PW'(1);
            unique case ({accept, pop})
                2'b10:   used <= used + CW'(1);
                2'b01:   used <= used - CW'(1);
                default: ;
            endcase
            unique case ({accept, fill})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: ;
            endcase
            filled <= (filled & ~(DEPTH'(pop) << rd_ptr)) | (DEPTH'(fill) << fill_ptr);
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_mem (
        .clock       (clock),
        .pc_we       (accept),
        .pc_waddr    (wr_ptr),
        .pc_wdata    (pc_in),
        .instr_we    (fill),
        .instr_waddr (fill_ptr),
        .instr_wdata (imem_rsp_data),
        .raddr       (rd_ptr),
        .rd_pc       (head_pc),
        .rd_instr    (head_instr)
    );

    // Every response must have a slot waiting for it (RUN) or be owed to the flush (FLUSH).
    assert property (@(posedge clock) disable iff (!reset)
        imem_rsp_valid |-> ((state == FETCH_RUN) ? (pending != '0) : (drop_cnt != '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC-register and memory models plus an in-order
// {pc, instr} scoreboard filled at request acceptance and drained at decode pops.
module tb_instr_fetch_unit;
    import cpu_fetch_pkg::*;

    logic        clock, reset;
    logic [31:0] pc_in;
    logic        pc_advance, redirect;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           n_acc, n_pop;
    bit           auto_mem;
    logic [31:0]  target;
    logic [31:0]  mem_q[$];
    fetch_entry_t sb[$];

    instr_fetch_unit #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_advance     (pc_advance),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task give_rsp();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_q.pop_front());
    endtask

    // One clock: sample settled outputs, score them, cross the edge, update the models.
    task cycle();
        bit           acc, pp;
        fetch_entry_t e;
        #1;
        acc = imem_req_valid && imem_req_ready;
        pp  = out_valid && out_ready && !redirect;
        chk("pc_advance", 64'(pc_advance), 64'(acc));
        if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(pc_in));
        if (pp) begin
            if (sb.size() == 0) chk("pop_unexpected", 64'(out_valid), 64'(0));
            else begin
                e = sb.pop_front();
                chk("out_pc", 64'(out_pc), 64'(e.pc));
                chk("out_instr", 64'(out_instr), 64'(e.instr));
            end
        end
        if (redirect) sb.delete();
        if (acc) begin
            e.pc     = pc_in;
            e.instr  = mem_word(pc_in);
            e.filled = 1'b1;
            sb.push_back(e);
            mem_q.push_back(pc_in);
            n_acc++;
        end
        @(posedge clock);
        @(negedge clock);
        if (redirect) pc_in = target;
        else if (acc) pc_in = pc_in + 32'd4;
        redirect = 1'b0;
        if (auto_mem && mem_q.size() != 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
    endtask

    task wait_out(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) cycle();
    endtask

    initial begin
        reset = 1'b0; pc_in = 32'h0040_0000; redirect = 1'b0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0; auto_mem = 1'b1;
        target = '0; n_acc = 0; n_pop = 0;
        repeat (2) @(negedge clock);
        #1;

        // Reset state, then release
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_pc", 64'(out_pc), 64'(0));
        chk("rst_out_instr", 64'(out_instr), 64'(0));
        chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
        chk("rst_pc_advance", 64'(pc_advance), 64'(0));
        reset = 1'b1;
        #1;
        chk("t1_req_valid", 64'(imem_req_valid), 64'(1));
        chk("t1_req_addr", 64'(imem_req_addr), 64'h0040_0000);
        chk("t1_pc_advance", 64'(pc_advance), 64'(1));

        // Decode stalled: queue fills after exactly DEPTH requests
        n_acc = 0;
        repeat (8) cycle();
        chk("t2_accepts", 64'(n_acc), 64'(4));
        chk("t2_req_valid", 64'(imem_req_valid), 64'(0));
        chk("t2_pc_advance", 64'(pc_advance), 64'(0));
        chk("t2_out_valid", 64'(out_valid), 64'(1));
        chk("t2_out_pc", 64'(out_pc), 64'h0040_0000);

        // Streaming: one instruction per cycle with no bubbles
        out_ready = 1'b1;
        n_pop = 0;
        repeat (12) begin
            if (out_valid) n_pop++;
            cycle();
        end
        chk("t3_no_gaps", 64'(n_pop), 64'(12));
        imem_req_ready = 1'b0;
        repeat (6) cycle();
        chk("t3_drained", 64'(out_valid), 64'(0));

        // Redirect with two outstanding requests
        auto_mem = 1'b0; imem_req_ready = 1'b1;
        repeat (2) cycle();
        target = 32'h0040_0100; redirect = 1'b1;
        #1;
        chk("t4_no_req_redirect", 64'(imem_req_valid), 64'(0));
        cycle();
        chk("t4_empty", 64'(out_valid), 64'(0));
        chk("t4_flush_no_req", 64'(imem_req_valid), 64'(0));
        cycle();
        chk("t4_flush_hold", 64'(imem_req_valid), 64'(0));
        give_rsp(); cycle();
        chk("t4_flush_mid", 64'(imem_req_valid), 64'(0));
        chk("t4_drop_hidden", 64'(out_valid), 64'(0));
        give_rsp(); cycle();
        chk("t4_resume", 64'(imem_req_valid), 64'(1));
        chk("t4_resume_addr", 64'(imem_req_addr), 64'h0040_0100);
        auto_mem = 1'b1;
        wait_out(10);
        chk("t4_out_valid", 64'(out_valid), 64'(1));
        chk("t4_first_pc", 64'(out_pc), 64'h0040_0100);
        imem_req_ready = 1'b0;
        repeat (6) cycle();
        chk("t4_drained", 64'(out_valid), 64'(0));

        // Redirect coinciding with a response and a pop, one more request outstanding
        auto_mem = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
        cycle();
        give_rsp(); cycle();
        chk("t5_head_valid", 64'(out_valid), 64'(1));
        cycle();
        target = 32'h0040_0200; redirect = 1'b1; out_ready = 1'b1;
        give_rsp();
        cycle();
        chk("t5_empty", 64'(out_valid), 64'(0));
        chk("t5_flush", 64'(imem_req_valid), 64'(0));
        give_rsp(); cycle();
        chk("t5_resume", 64'(imem_req_valid), 64'(1));
        chk("t5_resume_addr", 64'(imem_req_addr), 64'h0040_0200);
        auto_mem = 1'b1;
        wait_out(10);
        chk("t5_out_valid", 64'(out_valid), 64'(1));
        chk("t5_first_pc", 64'(out_pc), 64'h0040_0200);
        chk("t5_first_instr", 64'(out_instr), 64'(mem_word(32'h0040_0200)));
        imem_req_ready = 1'b0;
        repeat (6) cycle();

        // Asynchronous reset while flushing
        auto_mem = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (2) cycle();
        target = 32'h0040_0400; redirect = 1'b1;
        cycle();
        chk("t6_in_flush", 64'(imem_req_valid), 64'(0));
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_req_valid", 64'(imem_req_valid), 64'(0));
        chk("t6_rst_pc_advance", 64'(pc_advance), 64'(0));
        chk("t6_rst_out_valid", 64'(out_valid), 64'(0));
        chk("t6_rst_out_pc", 64'(out_pc), 64'(0));
        chk("t6_rst_out_instr", 64'(out_instr), 64'(0));
        @(negedge clock);
        mem_q.delete(); sb.delete();
        pc_in = 32'h0040_0300; reset = 1'b1;
        #1;
        chk("t6_run_req_valid", 64'(imem_req_valid), 64'(1));
        chk("t6_run_req_addr", 64'(imem_req_addr), 64'h0040_0300);
        auto_mem = 1'b1; out_ready = 1'b1;
        wait_out(10);
        chk("t6_out_valid", 64'(out_valid), 64'(1));
        chk("t6_first_pc", 64'(out_pc), 64'h0040_0300);
        repeat (8) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
